// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small circular FIFO through a valid/ready handshake.
// Queued bytes go out back-to-back: the next start bit replaces the stop-to-idle transition.
module uart_tx_buffered #(
  parameter int SYSTEM_CLK_MHZ = 25,
  parameter int BAUDRATE       = 9600,
  parameter int FIFO_DEPTH     = 4,
  localparam int CYCLES_PER_SYMBOL = (SYSTEM_CLK_MHZ * 1000000) / BAUDRATE,
  localparam int LW                = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_out,
  output logic          busy,
  output logic [LW-1:0] fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CYCLES_PER_SYMBOL + 1);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CYCLES_PER_SYMBOL - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            tx_q;
  logic            busy_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;

  logic            push, pop, have_data, sym_end;
  logic [7:0]      head;

  assign have_data  = (level_q != '0);
  assign sym_end    = (cnt_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign tx_ready   = (level_q < LW'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  // Pop exactly when the FSM loads a new start bit: from idle, or at the end of a stop bit.
  assign pop        = have_data & ((state_q == S_IDLE) | ((state_q == S_STOP) & sym_end));

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

  always_comb begin
    level_d = level_q;
    if (push & ~pop)      level_d = level_q + 1'b1;
    else if (pop & ~push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (have_data) begin
            shreg_q <= head;
            tx_q    <= 1'b0;
            cnt_q   <= CNT_RELOAD;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (sym_end) begin
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            bit_q   <= '0;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (sym_end) begin
            cnt_q <= CNT_RELOAD;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              bit_q   <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (sym_end) begin
            if (have_data) begin
              shreg_q <= head;
              tx_q    <= 1'b0;
              cnt_q   <= CNT_RELOAD;
              state_q <= S_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 10 clocks per symbol, FIFO depth 4.
// Line frames are checked symbol by symbol and also decoded by an independent receiver.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_out, busy;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .SYSTEM_CLK_MHZ(1),
    .BAUDRATE      (100000),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  // Receiver: samples mid-symbol just after each rising edge.
  logic [7:0] rx_q[$];
  logic [7:0] rx_sh = '0;
  int         rx_cnt = 0;
  bit         rx_act = 1'b0;
  int         rx_ferr = 0;

  initial forever begin
    @(posedge clk); #1;
    if (resetn !== 1'b1) rx_act = 1'b0;
    else if (!rx_act) begin
      if (tx_out === 1'b0) begin rx_act = 1'b1; rx_cnt = 0; end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_sh = {tx_out, rx_sh[7:1]};
      if (rx_cnt == 95) begin
        if (tx_out !== 1'b1) rx_ferr++;
        rx_q.push_back(rx_sh);
        rx_act = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the start-bit edge; returns just after the edge ending the stop bit.
  task automatic expect_frame(input string tag, input logic [7:0] b,
                              input bit push_last, input logic [7:0] pb);
    int   good;
    int   bgood;
    logic e;
    bgood = 0;
    for (int s = 0; s < 10; s++) begin
      e = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[s-1];
      good = 0;
      for (int c = 0; c < 10; c++) begin
        if (tx_out === e) good++;
        if (busy === 1'b1) bgood++;
        if (push_last && s == 9 && c == 9) begin tx_data = pb; tx_valid = 1'b1; end
        tick();
        tx_valid = 1'b0;
      end
      chk($sformatf("%s sym%0d", tag, s), good, 10);
    end
    chk($sformatf("%s busy", tag), bgood, 100);
  endtask

  int wait_cnt;
  int hi;

  initial begin
    tick(3);
    resetn = 1'b1;
    chk("rst tx_out", 32'(tx_out), 1);
    chk("rst tx_ready", 32'(tx_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst level", 32'(fifo_level), 0);
    tick(5);
    chk("idle tx_out", 32'(tx_out), 1);

    // Single byte 0x55
    tx_data = 8'h55; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    chk("t1 level after push", 32'(fifo_level), 1);
    chk("t1 busy after push", 32'(busy), 0);
    chk("t1 line after push", 32'(tx_out), 1);
    tick();
    chk("t1 start tx_out", 32'(tx_out), 0);
    chk("t1 start level", 32'(fifo_level), 0);
    chk("t1 start busy", 32'(busy), 1);
    expect_frame("t1 55", 8'h55, 1'b0, 8'h00);
    chk("t1 busy fall", 32'(busy), 0);
    chk("t1 idle tx_out", 32'(tx_out), 1);
    tick(10);

    // 0x00 then 0xFF back-to-back
    tx_data = 8'h00; tx_valid = 1'b1; tick();
    tx_data = 8'hFF; tick(); tx_valid = 1'b0;
    chk("t2 level", 32'(fifo_level), 1);
    chk("t2 start", 32'(tx_out), 0);
    expect_frame("t2 00", 8'h00, 1'b0, 8'h00);
    expect_frame("t2 FF", 8'hFF, 1'b0, 8'h00);
    chk("t2 busy end", 32'(busy), 0);
    chk("t2 level end", 32'(fifo_level), 0);

    // FIFO fill from reset with 0x01..0x06
    resetn = 1'b0; tick(); resetn = 1'b1;
    rx_q.delete();
    for (int i = 1; i <= 6; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      wait_cnt = 0;
      while (tx_ready !== 1'b1 && wait_cnt < 2000) begin tick(); wait_cnt++; end
      tick();
      if (i == 2) begin
        chk("t3 first pop tx_out", 32'(tx_out), 0);
        chk("t3 level after 2", 32'(fifo_level), 1);
      end
      if (i == 5) begin
        chk("t3 level full", 32'(fifo_level), 4);
        chk("t3 ready full", 32'(tx_ready), 0);
      end
      if (i == 6) chk("t3 wait for space", wait_cnt, 97);
    end
    tx_valid = 1'b0;
    wait_cnt = 0;
    while (rx_q.size() < 6 && wait_cnt < 1500) begin tick(); wait_cnt++; end
    chk("t3 rx count", rx_q.size(), 6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t3 rx byte%0d", k), (rx_q.size() > k) ? 32'(rx_q[k]) : 32'hxxxxxxxx, k + 1);
    wait_cnt = 0;
    while (busy === 1'b1 && wait_cnt < 200) begin tick(); wait_cnt++; end
    chk("t3 busy end", 32'(busy), 0);
    chk("t3 level end", 32'(fifo_level), 0);
    tick(5);

    // Push coinciding with pop at stop-bit end, level 1
    tx_data = 8'h3C; tx_valid = 1'b1; tick();
    tx_data = 8'hA5; tick(); tx_valid = 1'b0;
    chk("t4 level", 32'(fifo_level), 1);
    chk("t4 start", 32'(tx_out), 0);
    expect_frame("t4 3C", 8'h3C, 1'b1, 8'h96);
    chk("t4 level push+pop", 32'(fifo_level), 1);
    chk("t4 next start", 32'(tx_out), 0);
    chk("t4 busy", 32'(busy), 1);
    expect_frame("t4 A5", 8'hA5, 1'b0, 8'h00);
    expect_frame("t4 96", 8'h96, 1'b0, 8'h00);
    chk("t4 busy end", 32'(busy), 0);
    chk("t4 level end", 32'(fifo_level), 0);

    // Reset during data bit3 with two bytes queued
    rx_q.delete();
    tx_data = 8'hC3; tx_valid = 1'b1; tick();
    tx_data = 8'h11; tick();
    tx_data = 8'h22; tick(); tx_valid = 1'b0;
    chk("t5 level queued", 32'(fifo_level), 2);
    tick(43);
    chk("t5 bit3 low", 32'(tx_out), 0);
    chk("t5 level mid", 32'(fifo_level), 2);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk("t5 rst tx_out", 32'(tx_out), 1);
    chk("t5 rst level", 32'(fifo_level), 0);
    chk("t5 rst busy", 32'(busy), 0);
    chk("t5 rst ready", 32'(tx_ready), 1);
    hi = 0;
    for (int c = 0; c < 150; c++) begin
      if (tx_out === 1'b1 && busy === 1'b0) hi++;
      tick();
    end
    chk("t5 line quiet", hi, 150);
    tx_data = 8'h5A; tx_valid = 1'b1; tick(); tx_valid = 1'b0;
    tick();
    chk("t5 new start", 32'(tx_out), 0);
    expect_frame("t5 5A", 8'h5A, 1'b0, 8'h00);
    chk("t5 busy end", 32'(busy), 0);
    tick(3);
    chk("t5 rx count", rx_q.size(), 1);
    chk("t5 rx byte", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hxxxxxxxx, 32'h5A);
    chk("rx framing", rx_ferr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
